pc_sequencer: RTL and testbench

- Multi-cycle fetch/execute sequencer for the RV32 core.
- Owns the PC and drives the instruction-memory request/acknowledge handshake.
- Latches the fetched word for the control decoder and issues a one-cycle execute strobe that gates register-file and data-memory writes.
- Computes the next PC from decoder branch/jump/jump_reg flags and the ALU result; halts with a cause code on illegal or faulting conditions.

---
 rtl/pc_sequencer_pkg.sv | 42 ++++
 rtl/pc_next_calc.sv | 59 +++++
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 tb/tb_pc_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the fetch/execute sequencer and the control decoder:
//   - seq_state_t      : sequencer state encoding
//   - HALT_*           : halt cause codes reported on halt_cause
//   - OP_*             : RV32 control-flow opcodes
//   - imm_b/imm_j/imm_i: sign-extended immediates pulled straight from the word
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    localparam logic [1:0] HALT_NONE       = 2'd0;
    localparam logic [1:0] HALT_ILLEGAL    = 2'd1;
    localparam logic [1:0] HALT_MISALIGNED = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT    = 2'd3;

    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

    // B-type: imm[12|10:5] in [31:25], imm[4:1|11] in [11:7]
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-type: imm[20|10:1|11|19:12] in [31:12]
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // I-type: imm[11:0] in [31:20]
    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// ----------------------------------------------------------------------------
// pc_next_calc
// Combinational next-PC selection for the instruction currently in EXEC.
// Ports:
//   i_pc          address of the current instruction
//   i_instr       latched instruction word (immediates taken from here)
//   i_branch      decoder: conditional branch
//   i_jump        decoder: JAL
//   i_jump_reg    decoder: JALR
//   i_alu_zero    ALU result == 0 (XOR compare of rs1/rs2)
//   i_rs1_data    rs1 value, JALR base
//   o_target      next PC
//   o_misaligned  o_target is not word aligned
// ----------------------------------------------------------------------------
module pc_next_calc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_branch,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    input  logic        i_alu_zero,
    input  logic [31:0] i_rs1_data,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jalr_sum;
    logic        w_taken;
    logic        w_unused_opcode;

    assign w_pc_plus4 = i_pc + 32'd4;
    assign w_jalr_sum = i_rs1_data + imm_i(i_instr);

    // funct3[0] distinguishes BEQ (0) from BNE (1): inverting the zero flag
    // for BNE lets one XOR cover both.
    assign w_taken = i_branch & (i_alu_zero ^ i_instr[12]);

    // The decoder has already classified the opcode; only the flags matter here.
    assign w_unused_opcode = ^i_instr[6:0];

    always_comb begin
        // NOTE: default first so every path assigns o_target; otherwise a
        // missing else would infer a latch.
        o_target = w_pc_plus4;
        if (i_jump_reg) begin
            o_target = {w_jalr_sum[31:1], 1'b0};
        end else if (i_jump) begin
            o_target = i_pc + imm_j(i_instr);
        end else if (w_taken) begin
            o_target = i_pc + imm_b(i_instr);
        end
    end

    assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle fetch/execute sequencer for the RV32 core. Owns the PC, runs
// the instruction-memory req/ack handshake, latches the fetched word for the
// decoder and pulses exec_en for one cycle per instruction.
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   run                 permits starting the next fetch from IDLE
//   imem_req/addr       fetch request and address (= pc)
//   imem_ack/rdata      fetch completion and instruction word
//   instr, pc           latched instruction and its address
//   exec_en             one-cycle execute strobe
//   branch, jump, jump_reg, illegal   decoder flags for instr
//   alu_zero, rs1_data  ALU compare result and JALR base
//   link_sel, link_data write-back select for JAL/JALR and pc + 4
//   halted, halt_cause  sticky stop and its reason
//   instret             retired-instruction counter
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        exec_en,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        illegal,
    input  logic        alu_zero,
    input  logic [31:0] rs1_data,
    output logic        link_sel,
    output logic [31:0] link_data,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] instret
);

    seq_state_t  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic        r_imem_req;
    logic        r_exec_en;
    logic        r_halted;
    logic [1:0]  r_halt_cause;
    logic [7:0]  r_timeout_cnt;

    logic [31:0] w_target;
    logic        w_misaligned;

    pc_next_calc u_pc_next_calc (
        .i_pc         (r_pc),
        .i_instr      (r_instr),
        .i_branch     (branch),
        .i_jump       (jump),
        .i_jump_reg   (jump_reg),
        .i_alu_zero   (alu_zero),
        .i_rs1_data   (rs1_data),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // NOTE: state and outputs are all registered here with non-blocking
    // assignments, so every branch sees the pre-edge values regardless of
    // statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= 32'd0;
            r_instret     <= 32'd0;
            r_imem_req    <= 1'b0;
            r_exec_en     <= 1'b0;
            r_halted      <= 1'b0;
            r_halt_cause  <= HALT_NONE;
            r_timeout_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    // An ack on the last allowed cycle still completes the fetch.
                    if (imem_ack) begin
                        r_instr       <= imem_rdata;
                        r_imem_req    <= 1'b0;
                        r_exec_en     <= 1'b1;
                        r_timeout_cnt <= 8'd0;
                        r_state       <= ST_EXEC;
                    end else if (r_timeout_cnt == FETCH_TIMEOUT - 8'd1) begin
                        r_imem_req    <= 1'b0;
                        r_halted      <= 1'b1;
                        r_halt_cause  <= HALT_TIMEOUT;
                        r_timeout_cnt <= 8'd0;
                        r_state       <= ST_HALT;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 8'd1;
                    end
                end

                ST_EXEC: begin
                    r_exec_en <= 1'b0;
                    if (illegal) begin
                        r_halted     <= 1'b1;
                        r_halt_cause <= HALT_ILLEGAL;
                        r_state      <= ST_HALT;
                    end else if (w_misaligned) begin
                        // pc keeps the faulting instruction's address.
                        r_halted     <= 1'b1;
                        r_halt_cause <= HALT_MISALIGNED;
                        r_state      <= ST_HALT;
                    end else begin
                        r_pc      <= w_target;
                        r_instret <= r_instret + 32'd1;
                        if (run) begin
                            r_state    <= ST_FETCH;
                            r_imem_req <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_HALT: begin
                    // Sticky until rst.
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign instr      = r_instr;
    assign pc         = r_pc;
    assign exec_en    = r_exec_en;
    assign halted     = r_halted;
    assign halt_cause = r_halt_cause;
    assign instret    = r_instret;

    assign link_data = r_pc + 32'd4;
    assign link_sel  = r_exec_en & (jump | jump_reg);

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
// The bench plays instruction memory and decoder. Each instruction is built
// from an intended kind and offset; the reference model computes the next PC
// from that intent with plain 32-bit arithmetic.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          TMO    = 255;

    typedef enum int {K_ALU, K_BEQ, K_BNE, K_JAL, K_JALR, K_ILL} kind_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exec_en;
    logic        branch;
    logic        jump;
    logic        jump_reg;
    logic        illegal;
    logic        alu_zero;
    logic [31:0] rs1_data;
    logic        link_sel;
    logic [31:0] link_data;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] instret;

    pc_sequencer #(
        .RESET_PC      (RST_PC),
        .FETCH_TIMEOUT (8'(TMO))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .exec_en    (exec_en),
        .branch     (branch),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .illegal    (illegal),
        .alu_zero   (alu_zero),
        .rs1_data   (rs1_data),
        .link_sel   (link_sel),
        .link_data  (link_data),
        .halted     (halted),
        .halt_cause (halt_cause),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_halted;
    logic [1:0]  m_cause;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_b(input int off, input logic bne);
        logic [31:0] o;
        o = off;
        return {o[12], o[10:5], 5'd2, 5'd1, 2'b00, bne, o[4:1], o[11], 7'b110_0011};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [31:0] o;
        o = off;
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b110_1111};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [6:0] opcode);
        logic [31:0] o;
        o = imm;
        return {o[11:0], 5'd1, 3'b000, 5'd1, opcode};
    endfunction

    task automatic clear_flags();
        branch   = 1'b0;
        jump     = 1'b0;
        jump_reg = 1'b0;
        illegal  = 1'b0;
        alu_zero = 1'b0;
        rs1_data = 32'd0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        run      = 1'b0;
        imem_ack = 1'b0;
        clear_flags();
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        m_pc      = RST_PC;
        m_instret = 32'd0;
        m_halted  = 1'b0;
        m_cause   = 2'd0;
    endtask

    task automatic wait_req(input string tag);
        int cyc;
        cyc = 0;
        while (!imem_req && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(imem_req), 32'd1);
    endtask

    task automatic check_arch(input string tag);
        check({tag, "_pc"},      pc,                m_pc);
        check({tag, "_instret"}, instret,           m_instret);
        check({tag, "_halted"},  32'(halted),       32'(m_halted));
        check({tag, "_cause"},   32'(halt_cause),   32'(m_cause));
    endtask

    // One full fetch/execute: wait_n cycles without ack, then ack with the word.
    task automatic issue(input kind_t k, input int off, input logic az,
                         input logic [31:0] rs1v, input int wait_n, input logic run_next);
        logic [31:0] word;
        logic [31:0] offv;
        logic [31:0] target;
        offv = off;
        case (k)
            K_ALU:   word = enc_i(off, 7'b001_0011);
            K_BEQ:   word = enc_b(off, 1'b0);
            K_BNE:   word = enc_b(off, 1'b1);
            K_JAL:   word = enc_j(off);
            K_JALR:  word = enc_i(off, 7'b110_0111);
            default: word = 32'hFFFF_FFFF;
        endcase
        case (k)
            K_BEQ:   target = az  ? m_pc + offv : m_pc + 32'd4;
            K_BNE:   target = !az ? m_pc + offv : m_pc + 32'd4;
            K_JAL:   target = m_pc + offv;
            K_JALR:  target = (rs1v + offv) & 32'hFFFF_FFFE;
            default: target = m_pc + 32'd4;
        endcase

        run = 1'b1;
        wait_req("fetch_req");
        check("fetch_addr", imem_addr, m_pc);
        for (int i = 0; i < wait_n; i++) begin
            imem_ack = 1'b0;
            run      = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("fetch_hold_req",  32'(imem_req), 32'd1);
        check("fetch_hold_addr", imem_addr,     m_pc);

        imem_ack   = 1'b1;
        imem_rdata = word;
        branch     = (k == K_BEQ) || (k == K_BNE);
        jump       = (k == K_JAL);
        jump_reg   = (k == K_JALR);
        illegal    = (k == K_ILL);
        alu_zero   = az;
        rs1_data   = rs1v;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        run        = run_next;
        check("exec_en_on",  32'(exec_en),  32'd1);
        check("exec_instr",  instr,         word);
        check("exec_req",    32'(imem_req), 32'd0);
        check("exec_link_sel",  32'(link_sel), 32'((k == K_JAL) || (k == K_JALR)));
        check("exec_link_data", link_data,     m_pc + 32'd4);
        @(negedge clk);

        if (k == K_ILL) begin
            m_halted = 1'b1;
            m_cause  = 2'd1;
        end else if (target[1:0] != 2'b00) begin
            m_halted = 1'b1;
            m_cause  = 2'd2;
        end else begin
            m_pc      = target;
            m_instret = m_instret + 32'd1;
        end
        check("post_exec_en",   32'(exec_en),  32'd0);
        check("post_link_sel",  32'(link_sel), 32'd0);
        check("post_req",       32'(imem_req), 32'(!m_halted && run_next));
        check_arch("post");
        clear_flags();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet_bad;
        kind_t k;
        int off;
        logic [31:0] rs1v;

        rst        = 1'b1;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        clear_flags();
        do_reset();

        // Reset state
        check("rst_req",       32'(imem_req),  32'd0);
        check("rst_pc",        pc,             RST_PC);
        check("rst_addr",      imem_addr,      RST_PC);
        check("rst_instr",     instr,          32'd0);
        check("rst_exec_en",   32'(exec_en),   32'd0);
        check("rst_halted",    32'(halted),    32'd0);
        check("rst_cause",     32'(halt_cause),32'd0);
        check("rst_instret",   instret,        32'd0);
        check("rst_link_data", link_data,      RST_PC + 32'd4);

        // Directed sequence
        issue(K_ALU, 5, 1'b0, 32'd0, 2, 1'b1);
        check("plan_addi_pc", pc, 32'h104);
        check("plan_addi_instret", instret, 32'd1);
        issue(K_JAL, -244, 1'b0, 32'd0, 0, 1'b1);
        issue(K_BEQ, 8, 1'b1, 32'd0, 1, 1'b1);
        check("plan_beq_taken", pc, 32'h18);
        issue(K_JAL, -8, 1'b0, 32'd0, 0, 1'b1);
        issue(K_BEQ, 8, 1'b0, 32'd0, 0, 1'b1);
        check("plan_beq_not_taken", pc, 32'h14);
        issue(K_JAL, -4, 1'b0, 32'd0, 0, 1'b1);
        issue(K_BNE, 8, 1'b0, 32'd0, 0, 1'b0);
        check("plan_bne_taken", pc, 32'h18);
        issue(K_JAL, 8, 1'b0, 32'd0, 3, 1'b1);
        issue(K_JAL, -4, 1'b0, 32'd0, 0, 1'b1);
        check("plan_jal_back", pc, 32'h1C);
        issue(K_JAL, 4, 1'b0, 32'd0, 0, 1'b1);
        issue(K_JALR, 0, 1'b0, 32'h41, 0, 1'b1);
        check("plan_jalr_clear_lsb", pc, 32'h40);
        issue(K_JALR, 0, 1'b0, 32'hFFFF_FFFC, 0, 1'b1);
        issue(K_ALU, 0, 1'b0, 32'd0, 0, 1'b1);
        check("plan_pc_wrap", pc, 32'h0);
        issue(K_JAL, 32, 1'b0, 32'd0, 0, 1'b1);
        issue(K_JALR, 0, 1'b0, 32'h42, 0, 1'b1);
        check("plan_misaligned_halt",  32'(halted),     32'd1);
        check("plan_misaligned_cause", 32'(halt_cause), 32'd2);
        check("plan_misaligned_pc",    pc,              32'h20);
        repeat (3) @(negedge clk);
        check("misaligned_sticky_req", 32'(imem_req), 32'd0);

        // Randomized sequence
        do_reset();
        for (int n = 0; n < 40; n++) begin
            k    = kind_t'($urandom_range(0, 4));
            rs1v = 32'd0;
            case (k)
                K_ALU:   off = int'($urandom_range(0, 4095)) - 2048;
                K_BEQ,
                K_BNE:   off = (int'($urandom_range(0, 1023)) - 512) * 4;
                K_JAL:   off = (int'($urandom_range(0, 65535)) - 32768) * 4;
                default: begin
                    off  = (int'($urandom_range(0, 1023)) - 512) * 4;
                    rs1v = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
                end
            endcase
            issue(k, off, 1'($urandom_range(0, 1)), rs1v,
                  int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end

        // Ack on the last permitted fetch cycle wins over the timeout
        issue(K_ALU, 1, 1'b0, 32'd0, TMO - 1, 1'b1);
        check("ack_at_limit_halted", 32'(halted), 32'd0);

        // Illegal instruction
        issue(K_ILL, 0, 1'b0, 32'd0, 0, 1'b1);
        check("illegal_cause", 32'(halt_cause), 32'd1);
        quiet_bad = 0;
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (imem_req || exec_en) quiet_bad++;
        end
        imem_ack = 1'b0;
        check("illegal_quiet_cycles", 32'(quiet_bad), 32'd0);
        check_arch("illegal_sticky");

        // Fetch timeout
        do_reset();
        run = 1'b1;
        wait_req("tmo_req");
        repeat (TMO - 1) @(negedge clk);
        check("tmo_before_halted", 32'(halted),   32'd0);
        check("tmo_before_req",    32'(imem_req), 32'd1);
        @(negedge clk);
        check("tmo_halted", 32'(halted),     32'd1);
        check("tmo_cause",  32'(halt_cause), 32'd3);
        check("tmo_req",    32'(imem_req),   32'd0);

        // Reset arriving together with an ack during a fetch
        do_reset();
        issue(K_JAL, 64, 1'b0, 32'd0, 0, 1'b1);
        wait_req("rst_mid_req");
        rst        = 1'b1;
        run        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_req",     32'(imem_req), 32'd0);
        check("rst_mid_instr",   instr,         32'd0);
        check("rst_mid_pc",      pc,            RST_PC);
        check("rst_mid_exec_en", 32'(exec_en),  32'd0);
        check("rst_mid_instret", instret,       32'd0);
        @(negedge clk);
        imem_ack = 1'b0;
        check("idle_ack_ignored_exec", 32'(exec_en), 32'd0);
        check("idle_ack_ignored_instr", instr,       32'd0);
        m_pc      = RST_PC;
        m_instret = 32'd0;
        m_halted  = 1'b0;
        m_cause   = 2'd0;
        issue(K_ALU, 7, 1'b0, 32'd0, 1, 1'b0);
        check("recover_pc", pc, RST_PC + 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
